pcm_playback_buffer: RTL



---
 rtl/audio_pkg.sv | 36 +++
 rtl/pcm_fifo_mem.sv | 70 +++++++
 rtl/pcm_playback_buffer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared register map, control/clear bit positions and playback state encoding
// for the ARM-to-AC97 playback path.
package audio_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PCM_W  = 16;

    localparam logic [1:0] WA_DATA     = 2'd0;
    localparam logic [1:0] WA_CTRL     = 2'd1;
    localparam logic [1:0] WA_CLEAR    = 2'd2;

    localparam logic [1:0] RA_STATUS   = 2'd0;
    localparam logic [1:0] RA_CTRL     = 2'd1;
    localparam logic [1:0] RA_COUNTERS = 2'd2;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;
    localparam int unsigned CTRL_FLUSH  = 2;

    localparam int unsigned CLR_IRQ = 0;
    localparam int unsigned CLR_OVF = 1;
    localparam int unsigned CLR_UNF = 2;
    localparam int unsigned CLR_CNT = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } pb_state_e;

    typedef struct packed {
        logic [PCM_W-1:0] left;
        logic [PCM_W-1:0] right;
    } stereo_t;

endpackage

// File: rtl/pcm_fifo_mem.sv
// DEPTH x 32 sample FIFO with wrap-bit pointers and a registered head word,
// so the oldest sample is always ready to be latched on a pop.
module pcm_fifo_mem
    import audio_pkg::*;
#(
    parameter  int unsigned DEPTH = 64,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              SYS_CLK,
    input  logic              SYS_RST_N,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic [DATA_W-1:0] o_head,
    output logic [AW:0]       o_count,
    output logic              o_full,
    output logic              o_empty
);

    localparam int unsigned PW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [AW:0]       r_count;
    logic [DATA_W-1:0] r_head;
    logic [AW:0]       w_wr_ptr_nxt;
    logic [AW:0]       w_rd_ptr_nxt;
    logic              w_wr_now;

    assign o_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty  = (r_wr_ptr == r_rd_ptr);
    assign o_head   = r_head;
    assign o_count  = r_count;
    assign w_wr_now = i_push && !i_flush;

    // Flush drops everything by snapping the read pointer onto the write pointer
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        if (i_flush) begin
            w_rd_ptr_nxt = r_wr_ptr;
        end else begin
            if (i_push) w_wr_ptr_nxt = r_wr_ptr + PW'(1);
            if (i_pop)  w_rd_ptr_nxt = r_rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (w_wr_now) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

    // Head forwards the incoming word when it lands in the slot about to become head
    always_ff @(posedge SYS_CLK) begin
        if (!SYS_RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_wr_ptr_nxt - w_rd_ptr_nxt;
            if (w_wr_now && (r_wr_ptr == w_rd_ptr_nxt)) r_head <= i_wdata;
            else                                        r_head <= r_mem[w_rd_ptr_nxt[AW-1:0]];
        end
    end

endmodule

// File: rtl/pcm_playback_buffer.sv
// ARM register port, prime/run/underrun sequencing, counters and watermark IRQ
// feeding one stereo sample per AC97 frame request.
module pcm_playback_buffer
    import audio_pkg::*;
#(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned LOW_WM = 16
) (
    input  logic                    SYS_CLK,
    input  logic                    SYS_RST_N,
    input  logic                    wr_en,
    input  logic [1:0]              wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    rd_en,
    input  logic [1:0]              rd_addr,
    output logic [DATA_W-1:0]       rd_data,
    input  logic                    sample_req,
    output logic                    sample_valid,
    output logic [PCM_W-1:0]        pcm_left,
    output logic [PCM_W-1:0]        pcm_right,
    output logic [$clog2(DEPTH):0]  fill_level,
    output logic                    irq
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned FW   = AW + 1;
    localparam int unsigned PADW = 27 - FW;

    pb_state_e         r_state, w_state_nxt;
    logic              r_en, r_irq_en, r_irq_pend, r_ovf_flag, r_unf_flag;
    logic [7:0]        r_ovf_cnt;
    logic [15:0]       r_unf_cnt;
    logic              r_req_d;
    stereo_t           r_pend;

    logic              w_wr_data, w_wr_ctrl, w_wr_clr, w_flush, w_ctrl_upd;
    logic              w_req_run, w_pop, w_unf, w_push, w_ovf, w_irq_set;
    logic              w_full, w_empty;
    logic [DATA_W-1:0] w_head;
    logic [AW:0]       w_count;
    logic              w_irq_pend_nxt, w_irq_en_nxt;
    logic [7:0]        w_ovf_base;
    logic [15:0]       w_unf_base;
    logic [DATA_W-1:0] w_rd_mux;

    pcm_fifo_mem #(.DEPTH(DEPTH)) u_fifo (
        .SYS_CLK   (SYS_CLK),
        .SYS_RST_N (SYS_RST_N),
        .i_push    (w_push),
        .i_wdata   (wr_data),
        .i_pop     (w_pop),
        .i_flush   (w_flush),
        .o_head    (w_head),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign fill_level = w_count;

    assign w_wr_data  = wr_en && (wr_addr == WA_DATA);
    assign w_wr_ctrl  = wr_en && (wr_addr == WA_CTRL);
    assign w_wr_clr   = wr_en && (wr_addr == WA_CLEAR);
    assign w_flush    = w_wr_ctrl && wr_data[CTRL_FLUSH];
    assign w_ctrl_upd = w_wr_ctrl && !wr_data[CTRL_FLUSH];

    // A flush colliding with a RUN request starves that request
    assign w_req_run  = sample_req && (r_state == ST_RUN);
    assign w_pop      = w_req_run && !w_empty && !w_flush;
    assign w_unf      = w_req_run && (w_empty || w_flush);
    assign w_push     = w_wr_data && (!w_full || w_pop);
    assign w_ovf      = w_wr_data && w_full && !w_pop;
    assign w_irq_set  = w_pop && (w_count == FW'(LOW_WM));

    assign w_irq_pend_nxt = w_irq_set || (r_irq_pend && !(w_wr_clr && wr_data[CLR_IRQ]));
    assign w_irq_en_nxt   = w_ctrl_upd ? wr_data[CTRL_IRQ_EN] : r_irq_en;
    assign w_ovf_base     = (w_wr_clr && wr_data[CLR_CNT]) ? 8'd0  : r_ovf_cnt;
    assign w_unf_base     = (w_wr_clr && wr_data[CLR_CNT]) ? 16'd0 : r_unf_cnt;

    always_comb begin
        w_state_nxt = r_state;
        if (!r_en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_PRIME;
                ST_PRIME: if (w_count >= FW'(LOW_WM)) w_state_nxt = ST_RUN;
                ST_RUN:   if (w_unf) w_state_nxt = ST_PRIME;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (rd_addr)
            RA_STATUS:   w_rd_mux = {r_irq_pend, r_unf_flag, r_ovf_flag, r_state, PADW'(0), w_count};
            RA_CTRL:     w_rd_mux = {30'd0, r_irq_en, r_en};
            RA_COUNTERS: w_rd_mux = {r_ovf_cnt, 8'd0, r_unf_cnt};
            default:     w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge SYS_CLK) begin
        if (!SYS_RST_N) r_state <= ST_IDLE;
        else            r_state <= w_state_nxt;
    end

    // Requests resolve into r_pend, then surface one cycle later as sample_valid
    always_ff @(posedge SYS_CLK) begin
        if (!SYS_RST_N) begin
            r_en         <= 1'b0;
            r_irq_en     <= 1'b0;
            r_irq_pend   <= 1'b0;
            r_ovf_flag   <= 1'b0;
            r_unf_flag   <= 1'b0;
            r_ovf_cnt    <= '0;
            r_unf_cnt    <= '0;
            r_req_d      <= 1'b0;
            r_pend       <= '0;
            sample_valid <= 1'b0;
            pcm_left     <= '0;
            pcm_right    <= '0;
            rd_data      <= '0;
            irq          <= 1'b0;
        end else begin
            if (w_ctrl_upd) r_en <= wr_data[CTRL_EN];
            r_irq_en   <= w_irq_en_nxt;
            r_irq_pend <= w_irq_pend_nxt;
            r_ovf_flag <= w_ovf || (r_ovf_flag && !(w_wr_clr && wr_data[CLR_OVF]));
            r_unf_flag <= w_unf || (r_unf_flag && !(w_wr_clr && wr_data[CLR_UNF]));
            r_ovf_cnt  <= (w_ovf && (w_ovf_base != 8'hFF))   ? w_ovf_base + 8'd1  : w_ovf_base;
            r_unf_cnt  <= (w_unf && (w_unf_base != 16'hFFFF)) ? w_unf_base + 16'd1 : w_unf_base;
            r_req_d    <= sample_req;
            if (sample_req) r_pend <= w_pop ? stereo_t'(w_head) : '0;
            sample_valid <= r_req_d;
            if (r_req_d) begin
                pcm_left  <= r_pend.left;
                pcm_right <= r_pend.right;
            end
            if (rd_en) rd_data <= w_rd_mux;
            irq <= w_irq_pend_nxt && w_irq_en_nxt;
        end
    end

endmodule
